csi_header_decoder: RTL and testbench

CSI_HEADER_DECODER -- requirements
Module: csi_header_decoder

---
 rtl/csi_header_decoder.sv | 143 ++++++++++++++
 tb/tb_csi_header_decoder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/csi_header_decoder.sv
// CSI-2 packet header decoder: collects DI/WC0/WC1/ECC bytes, checks the header ECC, emits the decoded fields.
// Optional single-bit correction is enabled by defining CSI_HDR_ECC_CORRECT_EN.
module csi_header_decoder #(
    parameter logic [5:0] LONG_DT_MIN = 6'h10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_sop,
    output logic        hdr_valid,
    output logic [1:0]  vc,
    output logic [5:0]  dt,
    output logic [15:0] wc,
    output logic        is_long,
    output logic        ecc_corrected,
    output logic        ecc_error
);

    typedef enum logic [1:0] {IDLE, COLLECT, CHECK, EMIT} state_t;

    // Parity-bit pattern {P5..P0} contributed by each header data bit D0..D23.
    localparam logic [5:0] H_COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    state_t      state, state_nxt;
    logic [7:0]  hdr [4];
    logic [1:0]  byte_cnt;
    logic [5:0]  syndrome;
    logic [5:0]  parity;
    logic [23:0] data, fixed;
    logic        corr_nxt, err_nxt;

    assign data = {hdr[2], hdr[1], hdr[0]};

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid && in_sop) state_nxt = COLLECT;
                COLLECT: if (in_valid && !in_sop && byte_cnt == 2'd3) state_nxt = CHECK;
                CHECK:   state_nxt = EMIT;
                EMIT:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        parity = '0;
        for (int unsigned i = 0; i < 24; i++) begin
            for (int unsigned j = 0; j < 6; j++) begin
                parity[j] = parity[j] ^ (data[i] & H_COL[i][j]);
            end
        end
    end

    // Decode of the registered syndrome into the header presented at EMIT.
    always_comb begin
        fixed    = data;
        corr_nxt = 1'b0;
        err_nxt  = 1'b0;
`ifdef CSI_HDR_ECC_CORRECT_EN
        if (hdr[3][7:6] != 2'b00) begin
            err_nxt = 1'b1;
        end else if (syndrome != '0) begin
            if ($onehot(syndrome)) begin
                corr_nxt = 1'b1;
            end else begin
                err_nxt = 1'b1;
                for (int unsigned i = 0; i < 24; i++) begin
                    if (syndrome == H_COL[i]) begin
                        fixed[i] = ~data[i];
                        corr_nxt = 1'b1;
                        err_nxt  = 1'b0;
                    end
                end
            end
        end
`else
        err_nxt = (hdr[3][7:6] != 2'b00) || (syndrome != '0);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) hdr[i] <= '0;
            byte_cnt      <= '0;
            syndrome      <= '0;
            hdr_valid     <= 1'b0;
            vc            <= '0;
            dt            <= '0;
            wc            <= '0;
            is_long       <= 1'b0;
            ecc_corrected <= 1'b0;
            ecc_error     <= 1'b0;
        end else begin
            hdr_valid <= 1'b0;
            if (!enable) begin
                byte_cnt <= '0;
            end else begin
                case (state)
                    IDLE: if (in_valid && in_sop) begin
                        hdr[0]   <= in_byte;
                        byte_cnt <= 2'd1;
                    end
                    COLLECT: if (in_valid) begin
                        if (in_sop) begin
                            hdr[0]   <= in_byte;
                            byte_cnt <= 2'd1;
                        end else begin
                            hdr[byte_cnt] <= in_byte;
                            byte_cnt      <= byte_cnt + 2'd1;
                        end
                    end
                    CHECK: syndrome <= parity ^ hdr[3][5:0];
                    EMIT: begin
                        hdr_valid     <= 1'b1;
                        vc            <= fixed[7:6];
                        dt            <= fixed[5:0];
                        wc            <= fixed[23:8];
                        is_long       <= (fixed[5:0] >= LONG_DT_MIN);
                        ecc_corrected <= corr_nxt;
                        ecc_error     <= err_nxt;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csi_header_decoder.sv
// Directed bench for csi_header_decoder; expectations follow CSI_HDR_ECC_CORRECT_EN when defined.
module tb_csi_header_decoder;

    logic        clock = 1'b0;
    logic        reset, enable, in_valid, in_sop;
    logic [7:0]  in_byte;
    logic        hdr_valid, is_long, ecc_corrected, ecc_error;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;

    int n_checks = 0;
    int n_fail   = 0;
    int first, npulse;

`ifdef CSI_HDR_ECC_CORRECT_EN
    localparam bit CORR = 1'b1;
`else
    localparam bit CORR = 1'b0;
`endif

    csi_header_decoder #(.LONG_DT_MIN(6'h10)) dut (
        .clock(clock), .reset(reset), .enable(enable), .in_byte(in_byte),
        .in_valid(in_valid), .in_sop(in_sop), .hdr_valid(hdr_valid), .vc(vc),
        .dt(dt), .wc(wc), .is_long(is_long), .ecc_corrected(ecc_corrected),
        .ecc_error(ecc_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_hdr(input string tag, input logic [1:0] e_vc, input logic [5:0] e_dt,
                             input logic [15:0] e_wc, input logic e_long,
                             input logic e_corr, input logic e_err);
        check({tag, ".vc"}, 32'(vc), 32'(e_vc));
        check({tag, ".dt"}, 32'(dt), 32'(e_dt));
        check({tag, ".wc"}, 32'(wc), 32'(e_wc));
        check({tag, ".is_long"}, 32'(is_long), 32'(e_long));
        check({tag, ".ecc_corrected"}, 32'(ecc_corrected), 32'(e_corr));
        check({tag, ".ecc_error"}, 32'(ecc_error), 32'(e_err));
    endtask

    // Byte 3 is captured on the posedge before this task returns (at a negedge).
    task automatic send_hdr(input logic [7:0] b0, b1, b2, b3);
        @(negedge clock); in_valid = 1'b1; in_sop = 1'b1; in_byte = b0;
        @(negedge clock); in_sop = 1'b0; in_byte = b1;
        @(negedge clock); in_byte = b2;
        @(negedge clock); in_byte = b3;
        @(negedge clock); in_valid = 1'b0; in_byte = 8'h00;
    endtask

    task automatic send_hdr_gap(input logic [7:0] b0, b1, b2, b3);
        @(negedge clock); in_valid = 1'b1; in_sop = 1'b1; in_byte = b0;
        @(negedge clock); in_sop = 1'b0; in_byte = b1;
        @(negedge clock); in_valid = 1'b0; in_byte = 8'hEE;
        @(negedge clock); in_valid = 1'b1; in_byte = b2;
        @(negedge clock); in_byte = b3;
        @(negedge clock); in_valid = 1'b0; in_byte = 8'h00;
    endtask

    // Bounded observation: k counts negedges after the byte-3 capture edge.
    task automatic watch();
        first  = -1;
        npulse = 0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clock);
            if (hdr_valid === 1'b1) begin
                npulse++;
                if (first < 0) first = k;
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_byte = 8'h00;
        repeat (3) @(negedge clock);
        check("rst.hdr_valid", 32'(hdr_valid), 32'd0);
        check_hdr("rst", 2'd0, 6'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        send_hdr(8'h01, 8'h00, 8'h00, 8'h07); watch();
        check("clean.latency", 32'(first), 32'd2);
        check("clean.pulses", 32'(npulse), 32'd1);
        check_hdr("clean", 2'd0, 6'h01, 16'h0000, 1'b0, 1'b0, 1'b0);

        send_hdr_gap(8'h6B, 8'h34, 8'h12, 8'h00); watch();
        check("gap.latency", 32'(first), 32'd2);
        check_hdr("long", 2'd1, 6'h2B, 16'h1234, 1'b1, 1'b0, 1'b0);

        send_hdr(8'h0F, 8'h00, 8'h00, 8'h0F); watch();
        check_hdr("dt0f", 2'd0, 6'h0F, 16'h0000, 1'b0, 1'b0, 1'b0);
        send_hdr(8'h10, 8'h00, 8'h00, 8'h13); watch();
        check_hdr("dt10", 2'd0, 6'h10, 16'h0000, 1'b1, 1'b0, 1'b0);

        send_hdr(8'h01, 8'h00, 8'h00, 8'h00); watch();
        check("d0flip.pulses", 32'(npulse), 32'd1);
        check_hdr("d0flip", 2'd0, CORR ? 6'h00 : 6'h01, 16'h0000, 1'b0, CORR, !CORR);

        send_hdr(8'h01, 8'h01, 8'h00, 8'h07); watch();
        check_hdr("d8flip", 2'd0, 6'h01, CORR ? 16'h0000 : 16'h0001, 1'b0, CORR, !CORR);

        send_hdr(8'h03, 8'h00, 8'h00, 8'h00); watch();
        check_hdr("syn0c", 2'd0, 6'h03, 16'h0000, 1'b0, 1'b0, 1'b1);

        send_hdr(8'h00, 8'h00, 8'h00, 8'h04); watch();
        check_hdr("eccbit", 2'd0, 6'h00, 16'h0000, 1'b0, CORR, !CORR);
        send_hdr(8'h00, 8'h00, 8'h00, 8'hC0); watch();
        check_hdr("ecchi", 2'd0, 6'h00, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Restart: sop reasserted after two bytes.
        @(negedge clock); in_valid = 1'b1; in_sop = 1'b1; in_byte = 8'h2B;
        @(negedge clock); in_sop = 1'b0; in_byte = 8'h55;
        send_hdr(8'h0F, 8'h00, 8'h00, 8'h0F); watch();
        check("restart.latency", 32'(first), 32'd2);
        check("restart.pulses", 32'(npulse), 32'd1);
        check_hdr("restart", 2'd0, 6'h0F, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Reset after byte 2, then bytes without sop.
        @(negedge clock); in_valid = 1'b1; in_sop = 1'b1; in_byte = 8'h01;
        @(negedge clock); in_sop = 1'b0; in_byte = 8'h00;
        @(negedge clock); in_byte = 8'h00;
        @(negedge clock); in_valid = 1'b0; reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); in_valid = 1'b1; in_byte = (i == 3) ? 8'h07 : 8'h01;
        end
        @(negedge clock); in_valid = 1'b0; watch();
        check("rstmid.pulses", 32'(npulse), 32'd0);
        check_hdr("rstmid", 2'd0, 6'h00, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Enable low after byte 2; outputs keep the last emitted header.
        send_hdr(8'h10, 8'h00, 8'h00, 8'h13); watch();
        check("pre_en.pulses", 32'(npulse), 32'd1);
        @(negedge clock); in_valid = 1'b1; in_sop = 1'b1; in_byte = 8'h01;
        @(negedge clock); in_sop = 1'b0; in_byte = 8'h00;
        @(negedge clock); in_byte = 8'h00;
        @(negedge clock); in_valid = 1'b0; enable = 1'b0;
        @(negedge clock); enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); in_valid = 1'b1; in_byte = (i == 3) ? 8'h07 : 8'h00;
        end
        @(negedge clock); in_valid = 1'b0; watch();
        check("enlow.pulses", 32'(npulse), 32'd0);
        check_hdr("enlow", 2'd0, 6'h10, 16'h0000, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
